// File: rtl/shift_arbiter_32bit.sv
// shift_arbiter_32bit
// Shares one combinational SLL/SRL/SRA shifter between two requesters.
// Round-robin arbitration in IDLE, operands latched on grant, result
// registered in EXEC, and held on a valid/ready response channel in RESP.
module shift_arbiter_32bit #(
    parameter int WIDTH    = 32,
    parameter int AMT_BITS = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_x,
    input  logic [WIDTH-1:0] req0_y,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_x,
    input  logic [WIDTH-1:0] req1_y,
    input  logic [1:0]       req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_z,
    output logic             rsp_id,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_last_grant;
    logic             r_busy;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [1:0]       r_op;
    logic             r_id;
    logic [WIDTH-1:0] r_z;
    logic             r_rsp_id;

    logic                w_grant0;
    logic                w_grant1;
    logic                w_accept;
    logic                w_sat;
    logic [AMT_BITS-1:0] w_amt;
    logic [WIDTH-1:0]    w_shift;

    // Round-robin grant: only in IDLE; contention goes to the requester that
    // did not win last time. Held low while reset is asserted.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (rst_n && r_state == IDLE) begin
            if (req0_valid && req1_valid) begin
                w_grant0 = r_last_grant;
                w_grant1 = ~r_last_grant;
            end else begin
                w_grant0 = req0_valid;
                w_grant1 = req1_valid;
            end
        end
        w_accept = w_grant0 | w_grant1;
    end

    // Next-state decode for the IDLE -> EXEC -> RESP sequence.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = EXEC;
            EXEC:    w_state_next = RESP;
            RESP:    if (rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Shared shifter on the latched operands; any amount bit above the
    // in-range field saturates (y is always treated as unsigned).
    always_comb begin
        w_sat   = |r_y[WIDTH-1:AMT_BITS];
        w_amt   = r_y[AMT_BITS-1:0];
        w_shift = r_x;
        case (r_op)
            OP_SLL:  w_shift = w_sat ? '0 : (r_x << w_amt);
            OP_SRL:  w_shift = w_sat ? '0 : (r_x >> w_amt);
            OP_SRA:  w_shift = w_sat ? {WIDTH{r_x[WIDTH-1]}}
                                     : $unsigned($signed(r_x) >>> w_amt);
            default: w_shift = r_x;
        endcase
    end

    // State, busy flag and round-robin pointer (pointer moves only on a grant).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != IDLE);
            if (w_accept) r_last_grant <= w_grant1;
        end
    end

    // Capture the granted requester's operands and id.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x  <= '0;
            r_y  <= '0;
            r_op <= '0;
            r_id <= 1'b0;
        end else if (w_accept) begin
            r_x  <= w_grant1 ? req1_x  : req0_x;
            r_y  <= w_grant1 ? req1_y  : req0_y;
            r_op <= w_grant1 ? req1_op : req0_op;
            r_id <= w_grant1;
        end
    end

    // Register the shifter result in EXEC; it stays put through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_z      <= '0;
            r_rsp_id <= 1'b0;
        end else if (r_state == EXEC) begin
            r_z      <= w_shift;
            r_rsp_id <= r_id;
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign rsp_valid  = (r_state == RESP);
    assign rsp_z      = r_z;
    assign rsp_id     = r_rsp_id;
    assign busy       = r_busy;

endmodule

// File: tb/tb_shift_arbiter_32bit.sv
// Directed testbench for shift_arbiter_32bit: hand-computed vectors,
// arbitration order, back-pressure and mid-operation reset.
module tb_shift_arbiter_32bit;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_x, req0_y;
    logic [1:0]  req0_op;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_x, req1_y;
    logic [1:0]  req1_op;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_z;
    logic        rsp_id;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    bit tb_last  = 1'b1;   // expected round-robin pointer

    shift_arbiter_32bit #(.WIDTH(32), .AMT_BITS(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_x     (req0_x),
        .req0_y     (req0_y),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_x     (req1_x),
        .req1_y     (req1_y),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_z      (rsp_z),
        .rsp_id     (rsp_id),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    // Issue one operation from requester `id`, then verify the 2-cycle
    // latency, the result and the id. rsp_ready is expected high.
    task automatic do_op(input bit id, input logic [31:0] x, input logic [31:0] y,
                         input logic [1:0] op, input logic [31:0] exp_z, input string tag);
        bit got;
        @(negedge clk);
        if (id) begin
            req1_valid = 1'b1; req1_x = x; req1_y = y; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_x = x; req0_y = y; req0_op = op;
        end
        #1;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if ((id ? req1_ready : req0_ready) === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        check({tag, "_accept"}, {31'd0, got}, 32'd1);
        check({tag, "_other_rdy"}, {31'd0, (id ? req0_ready : req1_ready)}, 32'd0);
        tb_last = id;
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        check({tag, "_exec_valid"}, {31'd0, rsp_valid}, 32'd0);
        @(negedge clk); #1;
        check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        check({tag, "_rsp_z"}, rsp_z, exp_z);
        check({tag, "_rsp_id"}, {31'd0, rsp_id}, {31'd0, id});
        $display("op %s id=%0d x=%h y=%h op=%0d z=%h", tag, id, x, y, op, rsp_z);
    endtask

    initial begin
        logic [31:0] held_z;
        bit          exp_id;
        bit          got;

        rst_n = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_x = '0; req0_y = '0; req0_op = '0;
        req1_valid = 1'b0; req1_x = '0; req1_y = '0; req1_op = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_z", rsp_z, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic vectors
        do_op(1'b0, 32'hFFFFFFFF, 32'h10, 2'b10, 32'hFFFFFFFF, "sra_neg16");
        do_op(1'b1, 32'hAAAAAAAA, 32'h1,  2'b01, 32'h55555555, "srl_1");
        do_op(1'b1, 32'hAAAAAAAA, 32'h1,  2'b10, 32'hD5555555, "sra_1");
        do_op(1'b0, 32'h00000001, 32'd31, 2'b00, 32'h80000000, "sll_31");
        do_op(1'b0, 32'h00000001, 32'd32, 2'b00, 32'h00000000, "sll_32");
        do_op(1'b0, 32'h12345678, 32'd5,  2'b11, 32'h12345678, "pass");
        // Saturation
        do_op(1'b0, 32'hFFFFFFFF, 32'hFF,       2'b01, 32'h00000000, "sat_srl");
        do_op(1'b1, 32'hFFFFFFFF, 32'hFF,       2'b10, 32'hFFFFFFFF, "sat_sra_neg");
        do_op(1'b0, 32'h7FFFFFFF, 32'hFFFFFFFF, 2'b10, 32'h00000000, "sat_sra_pos");

        // Both requesters valid continuously: grants must alternate.
        @(negedge clk);
        req0_valid = 1'b1; req0_x = 32'h00000001; req0_y = 32'd4; req0_op = 2'b00;
        req1_valid = 1'b1; req1_x = 32'h80000000; req1_y = 32'd4; req1_op = 2'b10;
        for (int n = 0; n < 4; n++) begin
            exp_id = ~tb_last;
            #1;
            got = 1'b0;
            for (int k = 0; k < 10; k++) begin
                if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
                    got = 1'b1;
                    break;
                end
                @(negedge clk); #1;
            end
            check($sformatf("rr%0d_grant_seen", n), {31'd0, got}, 32'd1);
            check($sformatf("rr%0d_rdy", n), {30'd0, req1_ready, req0_ready},
                  exp_id ? 32'd2 : 32'd1);
            tb_last = exp_id;
            @(negedge clk);
            @(negedge clk); #1;
            check($sformatf("rr%0d_rsp_id", n), {31'd0, rsp_id}, {31'd0, exp_id});
            check($sformatf("rr%0d_rsp_z", n), rsp_z, exp_id ? 32'hF8000000 : 32'h00000010);
            $display("op rr%0d id=%0d z=%h", n, rsp_id, rsp_z);
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Back-pressure: result held, no grants while req1 is waiting.
        rsp_ready = 1'b0;
        do_op(1'b0, 32'h0000F000, 32'd8, 2'b01, 32'h000000F0, "bp");
        held_z = rsp_z;
        req1_valid = 1'b1; req1_x = 32'h3; req1_y = 32'd1; req1_op = 2'b00;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            check($sformatf("bp%0d_valid", c), {31'd0, rsp_valid}, 32'd1);
            check($sformatf("bp%0d_z", c), rsp_z, held_z);
            check($sformatf("bp%0d_rdy", c), {30'd0, req1_ready, req0_ready}, 32'd0);
            check($sformatf("bp%0d_busy", c), {31'd0, busy}, 32'd1);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_hs_no_grant", {31'd0, req1_ready}, 32'd0);
        @(negedge clk); #1;
        check("bp_idle_valid", {31'd0, rsp_valid}, 32'd0);
        check("bp_idle_busy", {31'd0, busy}, 32'd0);
        check("bp_idle_grant1", {31'd0, req1_ready}, 32'd1);
        tb_last = 1'b1;
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk); #1;
        check("bp_next_z", rsp_z, 32'h00000006);
        check("bp_next_id", {31'd0, rsp_id}, 32'd1);
        $display("op bp_next id=%0d z=%h", rsp_id, rsp_z);

        // Give req0 the last grant so the post-reset winner is meaningful.
        do_op(1'b0, 32'h1, 32'd0, 2'b00, 32'h1, "pre_rst");
        // Reset during EXEC.
        @(negedge clk);
        req1_valid = 1'b1; req1_x = 32'h5; req1_y = 32'd1; req1_op = 2'b00;
        #1;
        check("mr_grant1", {31'd0, req1_ready}, 32'd1);
        @(negedge clk);
        req0_valid = 1'b1; req0_x = 32'h9; req0_y = 32'd1; req0_op = 2'b00;
        #1;
        check("mr_in_exec", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("mr_rsp_z", rsp_z, 32'd0);
        check("mr_rsp_id", {31'd0, rsp_id}, 32'd0);
        check("mr_busy", {31'd0, busy}, 32'd0);
        check("mr_rdy", {30'd0, req1_ready, req0_ready}, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            check($sformatf("mr_stale%0d", c), {31'd0, rsp_valid}, 32'd0);
        end
        // Pointer back at reset value: requester 0 wins contention.
        @(negedge clk);
        req0_valid = 1'b1; req0_x = 32'h9; req0_y = 32'd1; req0_op = 2'b00;
        req1_valid = 1'b1; req1_x = 32'h5; req1_y = 32'd1; req1_op = 2'b00;
        #1;
        check("mr_winner", {30'd0, req1_ready, req0_ready}, 32'd1);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk); #1;
        check("mr_after_z", rsp_z, 32'h12);
        check("mr_after_id", {31'd0, rsp_id}, 32'd0);
        $display("op mr_after id=%0d z=%h", rsp_id, rsp_z);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
